// File: rtl/riscv_pkg.sv
// Shared core types: write-back arbiter state encoding, default starvation bound
// and the registered register-file write bundle.
package riscv_pkg;

  typedef enum logic {
    PIPE_PRI = 1'b0,
    LU_FORCE = 1'b1
  } wb_arb_state_e;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_wr_t;

  // x0 is hard-wired zero: a write to it handshakes but never touches the RF.
  function automatic logic rf_addr_writable(input logic [4:0] addr);
    return addr != 5'd0;
  endfunction

endpackage

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and the
// long-latency unit; the pipe wins unless the LU has been denied STARVE_LIMIT times.
module wb_write_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  output logic        pipe_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data
);

  wb_arb_state_e state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  logic          grant_pipe, grant_lu;
  rf_wr_t        wr_q, wr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PIPE_PRI;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Reset gates every grant so nothing decided during reset reaches the RF.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    grant_pipe = 1'b0;
    grant_lu   = 1'b0;
    pipe_stall = 1'b0;
    if (!rst) begin
      unique case (state_q)
        PIPE_PRI: begin
          if (pipe_valid)    grant_pipe = 1'b1;
          else if (lu_valid) grant_lu   = 1'b1;
          if (lu_valid && !grant_lu) begin
            wait_d = wait_q + 4'd1;
            if (wait_d == 4'(STARVE_LIMIT)) state_d = LU_FORCE;
          end else begin
            wait_d = 4'd0;
          end
        end
        LU_FORCE: begin
          // A withdrawn LU leaves the slot to the pipe rather than stalling it.
          if (lu_valid) begin
            grant_lu   = 1'b1;
            pipe_stall = pipe_valid;
          end else begin
            grant_pipe = pipe_valid;
          end
          wait_d  = 4'd0;
          state_d = PIPE_PRI;
        end
        default: state_d = PIPE_PRI;
      endcase
    end
  end

  assign lu_ready = grant_lu;

  always_comb begin
    wr_d    = wr_q;
    wr_d.we = 1'b0;
    if (grant_lu) begin
      wr_d.we   = rf_addr_writable(lu_addr);
      wr_d.addr = lu_addr;
      wr_d.data = lu_data;
    end else if (grant_pipe) begin
      wr_d.we   = rf_addr_writable(pipe_addr);
      wr_d.addr = pipe_addr;
      wr_d.data = pipe_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_q <= '0;
    else     wr_q <= wr_d;
  end

  assign rf_we   = wr_q.we;
  assign rf_addr = wr_q.addr;
  assign rf_data = wr_q.data;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed check of wb_write_arbiter against a cycle-level
// behavioural model of the write-port arbitration rules.
module tb_wb_write_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, lu_valid;
  logic [4:0]  pipe_addr, lu_addr;
  logic [31:0] pipe_data, lu_data;
  logic        pipe_stall, lu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int n_chk = 0;
  int n_fail = 0;

  // model state: consecutive LU denials and whether the next cycle is forced
  int m_run = 0;
  bit m_force = 1'b0;
  bit last_stall = 1'b0;
  bit last_ready = 1'b0;

  logic        pv, lv, r;
  logic [4:0]  pa, la;
  logic [31:0] pd, ld;

  wb_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs just after the edge, check handshakes, then check
  // the write that should land on rf_* after the next edge.
  task automatic step(input logic ipv, input logic [4:0] ipa, input logic [31:0] ipd,
                      input logic ilv, input logic [4:0] ila, input logic [31:0] ild,
                      input logic ir);
    bit g_pipe, g_lu, e_stall, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    pipe_valid = ipv; pipe_addr = ipa; pipe_data = ipd;
    lu_valid = ilv; lu_addr = ila; lu_data = ild; rst = ir;
    #1;
    g_pipe = 0; g_lu = 0; e_stall = 0;
    if (ir) begin
      m_run = 0; m_force = 0;
    end else if (m_force) begin
      m_force = 0; m_run = 0;
      if (ilv) begin g_lu = 1; e_stall = ipv; end
      else g_pipe = ipv;
    end else begin
      if (ipv) g_pipe = 1;
      else if (ilv) g_lu = 1;
      if (ilv && !g_lu) begin
        m_run++;
        if (m_run == LIMIT) begin m_force = 1; m_run = 0; end
      end else m_run = 0;
    end
    e_we   = (g_lu && ila != 0) || (g_pipe && ipa != 0);
    e_addr = g_lu ? ila : ipa;
    e_data = g_lu ? ild : ipd;
    chk("pipe_stall", pipe_stall, e_stall);
    chk("lu_ready", lu_ready, g_lu);
    last_stall = e_stall;
    last_ready = g_lu;
    @(posedge clk); #1;
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_addr", rf_addr, e_addr);
      chk("rf_data", rf_data, e_data);
    end
  endtask

  // Both sources valid for n cycles; the pipe only moves on when not stalled,
  // the LU only moves on when accepted.
  task automatic both_valid(input int n);
    for (int i = 0; i < n; i++) begin
      if (!last_stall) begin pa = 5'(i + 1); pd = $urandom; end
      if (last_ready || i == 0) begin la = 5'(20 + i); ld = $urandom; end
      step(1, pa, pd, 1, la, ld, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    pipe_valid = 0; pipe_addr = 0; pipe_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0; rst = 1;
    @(posedge clk); #1;
    // reset with requests present: no handshakes, no writes
    step(1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 1);
    step(1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 1);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_data", rf_data, 0);

    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5'd7, 32'h12345678, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // starvation: force on the 5th cycle, restart counting afterwards
    last_stall = 0; last_ready = 0;
    both_valid(12);
    step(0, 0, 0, 0, 0, 0, 0);

    // x0 writes handshake but never write
    step(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5'd0, 32'hCAFEF00D, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // reset landing on the forced cycle, then a full fresh starvation window
    last_stall = 0; last_ready = 0;
    both_valid(4);
    step(1, 5'd9, 32'hA5A5A5A5, 1, 5'd10, 32'h5A5A5A5A, 1);
    last_stall = 0; last_ready = 0;
    both_valid(6);
    step(0, 0, 0, 0, 0, 0, 0);

    // LU withdraws as the forced cycle begins: pipe goes through unstalled
    last_stall = 0; last_ready = 0;
    both_valid(4);
    step(1, 5'd11, 32'h0BADF00D, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    pv = 0; lv = 0; pa = 0; la = 0; pd = 0; ld = 0;
    last_stall = 0; last_ready = 0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 99) == 0);
      if (!(pv && last_stall)) begin
        pv = ($urandom_range(0, 9) < 7);
        pa = 5'($urandom_range(0, 31));
        pd = $urandom;
      end
      if (!(lv && !last_ready)) begin
        lv = ($urandom_range(0, 9) < 4);
        la = 5'($urandom_range(0, 31));
        ld = $urandom;
      end
      step(pv, pa, pd, lv, la, ld, r);
      if (r) begin last_stall = 0; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
